// File: rtl/mu0_loader_if.sv
// Byte-stream handshake and program-memory write port between the boot host,
// the loader and the MU0 program memory.
interface mu0_loader_if #(
  parameter int MAXWIDTH = 16,
  parameter int MAXDEPTH = 12
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                mem_we;
  logic [MAXDEPTH-1:0] mem_addr;
  logic [MAXWIDTH-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mu0_loader.sv
// MU0 boot loader: length-prefixed big-endian word stream into program memory,
// 8-bit zero-sum checksum, core held in reset until a good image lands.
module mu0_loader #(
  parameter int MAXWIDTH = 16,
  parameter int MAXDEPTH = 12
) (
  input  logic                clk,
  input  logic                reset,
  mu0_loader_if.slave         bus,
  output logic [MAXDEPTH:0]   word_count_o,
  output logic                cpu_reset_o,
  output logic                done_o,
  output logic                error_o
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] CAP = 16'(1 << MAXDEPTH);

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [MAXDEPTH:0]   len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          sum_q, sum_d;
  logic [MAXDEPTH-1:0] addr_q, addr_d;
  logic [MAXDEPTH-1:0] maddr_q, maddr_d;
  logic [MAXWIDTH-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [MAXDEPTH:0]   wc_q, wc_d;
  logic                busy;
  logic                accept;
  logic [15:0]         nlen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LEN_HI;
      len_hi_q <= '0;
      len_q    <= '0;
      hi_q     <= '0;
      sum_q    <= '0;
      addr_q   <= '0;
      maddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      wc_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      hi_q     <= hi_d;
      sum_q    <= sum_d;
      addr_q   <= addr_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      wc_q     <= wc_d;
    end
  end

  // Ready depends only on state and reset, never on in_valid.
  assign busy   = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept = bus.in_valid && busy && !reset;
  assign nlen   = {len_hi_q, bus.in_data};

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    hi_d     = hi_q;
    sum_d    = sum_q;
    addr_d   = addr_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    wc_d     = wc_q;
    if (accept) begin
      sum_d = sum_q + bus.in_data;
      unique case (state_q)
        S_LEN_HI: begin
          len_hi_d = bus.in_data;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = nlen[MAXDEPTH:0];
          if (nlen > CAP)        state_d = S_ERROR;
          else if (nlen == 16'd0) state_d = S_CSUM;
          else                   state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = bus.in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = {hi_q, bus.in_data};
          addr_d  = addr_q + 1'b1;
          wc_d    = wc_q + 1'b1;
          state_d = (wc_d == len_q) ? S_CSUM : S_DATA_HI;
        end
        S_CSUM: state_d = (sum_d == 8'd0) ? S_DONE : S_ERROR;
        default: state_d = state_q;
      endcase
    end
  end

  assign bus.in_ready  = busy && !reset;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign word_count_o  = wc_q;
  assign cpu_reset_o   = (state_q != S_DONE);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = (state_q == S_ERROR);

endmodule

// File: tb/tb_mu0_loader.sv
// Directed bench for mu0_loader: good/bad/empty/oversize images, backpressure
// and reset mid-load, with hand-computed expectations.
module tb_mu0_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] word_count;
  logic        cpu_reset, done, error;

  mu0_loader_if #(.MAXWIDTH(16), .MAXDEPTH(12)) bus ();

  mu0_loader #(.MAXWIDTH(16), .MAXDEPTH(12)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .word_count_o(word_count), .cpu_reset_o(cpu_reset),
    .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nwr = 0;
  int nacc = 0;
  logic [11:0] wa [64];
  logic [15:0] wd [64];

  // Single-cycle strobes are stable across the negedge, so each is logged once.
  always @(negedge clk) begin
    if (bus.mem_we && nwr < 64) begin
      wa[nwr] = bus.mem_addr;
      wd[nwr] = bus.mem_wdata;
      nwr++;
    end
    if (bus.in_valid && bus.in_ready) nacc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gaps);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      bus.in_data = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [7:0] good [9];
  int base, abase;

  task automatic chk_good_writes(input string tag);
    chk({tag, "_nwr"}, 32'(nwr - base), 32'd3);
    chk({tag, "_a0"}, 32'(wa[base]),   32'h0);
    chk({tag, "_d0"}, 32'(wd[base]),   32'h000A);
    chk({tag, "_a1"}, 32'(wa[base+1]), 32'h1);
    chk({tag, "_d1"}, 32'(wd[base+1]), 32'h2003);
    chk({tag, "_a2"}, 32'(wa[base+2]), 32'h2);
    chk({tag, "_d2"}, 32'(wd[base+2]), 32'h7000);
  endtask

  initial begin
    good = '{8'h00, 8'h03, 8'h00, 8'h0A, 8'h20, 8'h03, 8'h70, 8'h00, 8'h60};
    bus.in_data = 8'h00; bus.in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we",    32'(bus.mem_we),   32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_wc",    32'(word_count),   32'd0);
    chk("rst_cpu",   32'(cpu_reset),    32'd1);
    chk("rst_done",  32'(done),         32'd0);
    chk("rst_err",   32'(error),        32'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Good image at full rate, with cycle-level checks on the last word.
    base = nwr; abase = nacc;
    for (int i = 0; i < 8; i++) send(good[i], 0);
    chk("last_we",    32'(bus.mem_we),    32'd1);
    chk("last_addr",  32'(bus.mem_addr),  32'h2);
    chk("last_wdata", 32'(bus.mem_wdata), 32'h7000);
    chk("last_wc",    32'(word_count),    32'd3);
    chk("last_cpu",   32'(cpu_reset),     32'd1);
    send(good[8], 0);
    chk("cs_done",  32'(done),         32'd1);
    chk("cs_cpu",   32'(cpu_reset),    32'd0);
    chk("cs_ready", 32'(bus.in_ready), 32'd0);
    chk("cs_we",    32'(bus.mem_we),   32'd0);
    chk("cs_err",   32'(error),        32'd0);
    @(posedge clk); #1;
    chk_good_writes("good");
    chk("good_acc", 32'(nacc - abase), 32'd9);
    send(8'h55, 0);
    chk("good_sticky", 32'(done), 32'd1);

    // Bad checksum.
    do_reset();
    base = nwr;
    for (int i = 0; i < 8; i++) send(good[i], 0);
    send(8'h61, 0);
    @(posedge clk); #1;
    chk("bad_nwr",  32'(nwr - base), 32'd3);
    chk("bad_err",  32'(error),      32'd1);
    chk("bad_done", 32'(done),       32'd0);
    chk("bad_cpu",  32'(cpu_reset),  32'd1);

    // Empty image.
    do_reset();
    base = nwr;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    @(posedge clk); #1;
    chk("empty_nwr",  32'(nwr - base), 32'd0);
    chk("empty_done", 32'(done),       32'd1);
    chk("empty_wc",   32'(word_count), 32'd0);

    // Oversize length 0x1001.
    do_reset();
    base = nwr;
    send(8'h10, 0);
    send(8'h01, 0);
    chk("over_err",   32'(error),        32'd1);
    chk("over_ready", 32'(bus.in_ready), 32'd0);
    abase = nacc;
    send(8'h00, 0); send(8'h12, 0); send(8'h34, 0);
    chk("over_acc", 32'(nacc - abase), 32'd0);
    chk("over_nwr", 32'(nwr - base),   32'd0);

    // Exactly full memory (0x1000) is a legal length.
    do_reset();
    send(8'h10, 0);
    send(8'h00, 0);
    chk("cap_err",   32'(error),        32'd0);
    chk("cap_ready", 32'(bus.in_ready), 32'd1);

    // Backpressure: valid 1-0-0-1 with junk data on idle cycles.
    do_reset();
    base = nwr; abase = nacc;
    for (int i = 0; i < 9; i++) send(good[i], 2);
    chk_good_writes("bp");
    chk("bp_acc",  32'(nacc - abase), 32'd9);
    chk("bp_done", 32'(done),         32'd1);
    chk("bp_cpu",  32'(cpu_reset),    32'd0);

    // Reset after byte 5, then reload.
    do_reset();
    base = nwr;
    for (int i = 0; i < 5; i++) send(good[i], 0);
    chk("mid_wc", 32'(word_count), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_ready", 32'(bus.in_ready),  32'd0);
    chk("mid_we",    32'(bus.mem_we),    32'd0);
    chk("mid_addr",  32'(bus.mem_addr),  32'd0);
    chk("mid_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mid_wc0",   32'(word_count),    32'd0);
    chk("mid_cpu",   32'(cpu_reset),     32'd1);
    reset = 1'b0;
    base = nwr;
    for (int i = 0; i < 9; i++) send(good[i], 0);
    @(posedge clk); #1;
    chk_good_writes("reload");
    chk("reload_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
